// File: rtl/multdiv_issue_ctrl.sv
// rtl/multdiv_issue_ctrl.sv - mult/div issue, stall and writeback controller
// Optional WAIT watchdog is enabled by defining MDCTRL_TIMEOUT_EN.
module multdiv_issue_ctrl #(
  parameter logic [4:0]  RSTATUS_REG   = 5'd30,
  parameter logic [31:0] EXC_CODE_MULT = 32'd4,
  parameter logic [31:0] EXC_CODE_DIV  = 32'd5
`ifdef MDCTRL_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC   = 64
`endif
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic        in_is_div,
  input  logic [31:0] in_opA,
  input  logic [31:0] in_opB,
  input  logic [4:0]  in_rd,
  input  logic        in_flush,
  output logic        stall,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_multRDY,
  input  logic        md_divRDY,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_exception
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_stall;
  logic        w_accept;
  logic        w_rdy;
  logic        w_timeout;
  logic        w_finish;
  logic [31:0] r_opA;
  logic [31:0] r_opB;
  logic [4:0]  r_rd;
  logic        r_is_div;
  logic        r_ctrl_mult;
  logic        r_ctrl_div;
  logic        r_wb_valid;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        r_wb_exc;

  assign w_accept = (r_state == S_IDLE) && in_valid && !in_flush;
  // Only the RDY of the operation actually issued may end the wait.
  assign w_rdy    = r_is_div ? md_divRDY : md_multRDY;
  assign w_finish = (r_state == S_WAIT) && !in_flush && (w_rdy || w_timeout);

`ifdef MDCTRL_TIMEOUT_EN
  logic [6:0] r_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (r_state != S_WAIT) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 7'd1;
    end
  end

  assign w_timeout = (r_state == S_WAIT) && (r_cnt == 7'(TIMEOUT_CYC - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stall = in_valid && !in_flush;
        if (w_accept) w_next = S_START;
      end
      S_START: begin
        w_stall = 1'b1;
        w_next  = in_flush ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        w_stall = 1'b1;
        if (in_flush)                 w_next = S_IDLE;
        else if (w_rdy || w_timeout)  w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_opA       <= '0;
      r_opB       <= '0;
      r_rd        <= '0;
      r_is_div    <= 1'b0;
      r_ctrl_mult <= 1'b0;
      r_ctrl_div  <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_data   <= '0;
      r_wb_exc    <= 1'b0;
    end else begin
      r_ctrl_mult <= w_accept && !in_is_div;
      r_ctrl_div  <= w_accept && in_is_div;
      r_wb_valid  <= w_finish;
      if (w_accept) begin
        r_opA    <= in_opA;
        r_opB    <= in_opB;
        r_rd     <= in_rd;
        r_is_div <= in_is_div;
      end
      if (w_finish) begin
        // A watchdog expiry without RDY is reported like a unit exception.
        if (w_rdy && !md_exception) begin
          r_wb_rd   <= r_rd;
          r_wb_data <= md_result;
          r_wb_exc  <= 1'b0;
        end else begin
          r_wb_rd   <= RSTATUS_REG;
          r_wb_data <= r_is_div ? EXC_CODE_DIV : EXC_CODE_MULT;
          r_wb_exc  <= 1'b1;
        end
      end
    end
  end

  assign stall        = w_stall;
  assign md_operandA  = r_opA;
  assign md_operandB  = r_opB;
  assign md_ctrl_MULT = r_ctrl_mult;
  assign md_ctrl_DIV  = r_ctrl_div;
  assign wb_valid     = r_wb_valid;
  assign wb_rd        = r_wb_rd;
  assign wb_data      = r_wb_data;
  assign wb_exception = r_wb_exc;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// tb/tb_multdiv_issue_ctrl.sv - randomized self-checking bench for multdiv_issue_ctrl
module tb_multdiv_issue_ctrl;

  localparam int TO_CYC = 64;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_is_div, in_flush;
  logic [31:0] in_opA, in_opB;
  logic [4:0]  in_rd;
  logic        stall;
  logic [31:0] md_operandA, md_operandB;
  logic        md_ctrl_MULT, md_ctrl_DIV;
  logic [31:0] md_result;
  logic        md_exception, md_multRDY, md_divRDY;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_exception;

  int n_checks = 0;
  int n_fail   = 0;

  multdiv_issue_ctrl dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_is_div(in_is_div),
    .in_opA(in_opA), .in_opB(in_opB), .in_rd(in_rd), .in_flush(in_flush),
    .stall(stall), .md_operandA(md_operandA), .md_operandB(md_operandB),
    .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV), .md_result(md_result),
    .md_exception(md_exception), .md_multRDY(md_multRDY), .md_divRDY(md_divRDY),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_exception(wb_exception)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference multdiv: signed product overflow or zero divisor raises the exception.
  function automatic void model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output bit exc);
    longint p;
    if (is_div) begin
      exc = (b == 32'd0);
      res = exc ? 32'hdead_beef : 32'($signed(a) / $signed(b));
    end else begin
      p   = longint'($signed(a)) * longint'($signed(b));
      res = p[31:0];
      exc = (p != longint'($signed(res)));
    end
  endfunction

  function automatic logic [31:0] ctrl2();
    return {30'd0, md_ctrl_MULT, md_ctrl_DIV};
  endfunction

  task automatic flush_tail();
    @(negedge clock);
    chk("flush_wbv", 32'(wb_valid), 32'd0);
    chk("flush_ctrl", ctrl2(), 32'd0);
    in_flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush_stall", 32'(stall), 32'd0);
    for (int j = 0; j < 3; j++) begin
      md_divRDY  = 1'b1;
      md_multRDY = 1'b1;
      md_result  = $urandom;
      @(negedge clock);
      chk("late_rdy_wbv", 32'(wb_valid), 32'd0);
      chk("late_rdy_stall", 32'(stall), 32'd0);
    end
    md_divRDY  = 1'b0;
    md_multRDY = 1'b0;
  endtask

  // Called at a negedge with the controller idle; returns at a negedge with it idle.
  // flush_at: -2 none, -1 during START, k>=0 during WAIT cycle k.
  task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int delay, input int flush_at);
    logic [31:0] res;
    bit          exc;
    logic [4:0]  erd;
    logic [31:0] edata;
    model(is_div, a, b, res, exc);
    erd   = exc ? 5'd30 : rd;
    edata = exc ? (is_div ? 32'd5 : 32'd4) : res;

    in_valid = 1'b1; in_is_div = is_div; in_opA = a; in_opB = b; in_rd = rd;
    in_flush = 1'b0; md_multRDY = 1'b0; md_divRDY = 1'b0;
    #1;
    chk("idle_stall", 32'(stall), 32'd1);
    chk("idle_ctrl", ctrl2(), 32'd0);

    @(negedge clock);
    chk("start_ctrl", ctrl2(), is_div ? 32'd1 : 32'd2);
    chk("start_stall", 32'(stall), 32'd1);
    chk("start_opA", md_operandA, a);
    chk("start_opB", md_operandB, b);
    chk("start_wbv", 32'(wb_valid), 32'd0);
    md_multRDY   = 1'($urandom);
    md_divRDY    = 1'($urandom);
    md_result    = $urandom;
    md_exception = 1'($urandom);
    in_flush     = (flush_at == -1);
    if (flush_at == -1) begin
      flush_tail();
      return;
    end

    for (int k = 0; k <= delay; k++) begin
      @(negedge clock);
      chk("wait_ctrl", ctrl2(), 32'd0);
      chk("wait_stall", 32'(stall), 32'd1);
      chk("wait_opA", md_operandA, a);
      chk("wait_opB", md_operandB, b);
      chk("wait_wbv", 32'(wb_valid), 32'd0);
      in_opA = $urandom;
      in_opB = $urandom;
      if (is_div) begin
        md_divRDY  = (k == delay);
        md_multRDY = 1'($urandom);
      end else begin
        md_multRDY = (k == delay);
        md_divRDY  = 1'($urandom);
      end
      md_result    = (k == delay) ? res : $urandom;
      md_exception = (k == delay) ? exc : 1'($urandom);
      in_flush     = (k == flush_at);
      if (k == flush_at) begin
        flush_tail();
        return;
      end
    end

    @(negedge clock);
    chk("done_wbv", 32'(wb_valid), 32'd1);
    chk("done_rd", 32'(wb_rd), 32'(erd));
    chk("done_data", wb_data, edata);
    chk("done_exc", 32'(wb_exception), 32'(exc));
    in_valid   = 1'($urandom);
    in_flush   = 1'($urandom);
    md_divRDY  = 1'b0;
    md_multRDY = 1'($urandom);
    #1;
    chk("done_stall", 32'(stall), 32'd0);

    @(negedge clock);
    chk("post_wbv", 32'(wb_valid), 32'd0);
    in_valid = 1'b0; in_flush = 1'b0; md_multRDY = 1'b0; md_divRDY = 1'b0;
  endtask

  initial begin
    bit          r_div;
    logic [31:0] ra, rb;
    int          dly, fl;

    reset_n = 1'b0;
    in_valid = 1'b0; in_is_div = 1'b0; in_opA = '0; in_opB = '0; in_rd = '0; in_flush = 1'b0;
    md_result = '0; md_exception = 1'b0; md_multRDY = 1'b0; md_divRDY = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_ctrl", ctrl2(), 32'd0);
    chk("rst_wbv", 32'(wb_valid), 32'd0);
    chk("rst_opA", md_operandA, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    run_op(1'b0, 32'd7, 32'd6, 5'd3, 0, -2);
    run_op(1'b1, 32'd100, 32'd7, 5'd9, 32, -2);
    run_op(1'b1, 32'd5, 32'd0, 5'd12, 4, -2);
    run_op(1'b1, 32'd1000, 32'd3, 5'd7, 10, 2);
    run_op(1'b0, 32'd9, 32'd9, 5'd0, 2, 2);

    // Asynchronous reset during START (pulse high) and during WAIT.
    for (int s = 1; s <= 2; s++) begin
      in_valid = 1'b1; in_is_div = 1'b0; in_opA = 32'd11; in_opB = 32'd13; in_rd = 5'd4;
      md_multRDY = 1'b0; md_divRDY = 1'b0;
      repeat (s) @(negedge clock);
      #2;
      reset_n  = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("arst_ctrl", ctrl2(), 32'd0);
      chk("arst_wbv", 32'(wb_valid), 32'd0);
      chk("arst_opA", md_operandA, 32'd0);
      chk("arst_wb_data", wb_data, 32'd0);
      chk("arst_wb_rd", 32'(wb_rd), 32'd0);
      chk("arst_stall", 32'(stall), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      run_op(1'b0, 32'h0001_0000, 32'h0001_0000, 5'd6, 0, -2);
    end

    // Div whose RDY never arrives, while multRDY is held high.
    in_valid = 1'b1; in_is_div = 1'b1; in_opA = 32'd77; in_opB = 32'd3; in_rd = 5'd8;
    md_divRDY = 1'b0; md_multRDY = 1'b1; in_flush = 1'b0;
    @(negedge clock);
    for (int k = 0; k < TO_CYC; k++) begin
      @(negedge clock);
      chk("to_wait_wbv", 32'(wb_valid), 32'd0);
      chk("to_wait_stall", 32'(stall), 32'd1);
    end
`ifdef MDCTRL_TIMEOUT_EN
    @(negedge clock);
    chk("to_wbv", 32'(wb_valid), 32'd1);
    chk("to_rd", 32'(wb_rd), 32'd30);
    chk("to_data", wb_data, 32'd5);
    chk("to_exc", 32'(wb_exception), 32'd1);
    in_valid = 1'b0; md_multRDY = 1'b0;
    @(negedge clock);
`else
    repeat (16) begin
      @(negedge clock);
      chk("hold_wbv", 32'(wb_valid), 32'd0);
    end
    in_flush = 1'b1;
    @(negedge clock);
    chk("hold_flush_wbv", 32'(wb_valid), 32'd0);
    in_flush = 1'b0; in_valid = 1'b0; md_multRDY = 1'b0;
    #1;
    chk("hold_flush_stall", 32'(stall), 32'd0);
    @(negedge clock);
`endif

    for (int n = 0; n < 60; n++) begin
      r_div = 1'($urandom);
      ra = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 2000)) : $urandom;
      rb = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 2000)) : $urandom;
      if (r_div && $urandom_range(0, 5) == 0) rb = 32'd0;
      dly = r_div ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 3));
      fl  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, dly + 1)) - 1 : -2;
      run_op(r_div, ra, rb, 5'($urandom), dly, fl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
